reg_wb_arbiter: RTL
===================

Name: reg_wb_arbiter

Overview:
Writeback controller for the single register-file write port.
- Arbitrates each cycle between the in-order pipeline writeback (ALU result or load data) and a multi-cycle multiply/divide unit, which returns two results: lo to rd, hi to R0.
- Drives the 2-bit destination select for the register-destination mux (0 = rd field, 1 = rt field, 2 = fixed R0), plus write enable, address and data.
- Sits between the WB stage, the mul/div unit and the register file.

Parameters:
DATA_W, 16, register data width
ADDR_W, 4, register address width
HI_REG, 0, register that receives the mul/div hi word
STARVE_MAX, 4, consecutive pipeline writes tolerated while a mul/div write is pending

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
alu_valid  in  1  ALU result valid in WB
alu_rd  in  ADDR_W  ALU destination (rd field)
alu_data  in  DATA_W  ALU result
ld_valid  in  1  load data valid in WB
ld_rt  in  ADDR_W  load destination (rt field)
ld_data  in  DATA_W  load data
md_valid  in  1  mul/div result offered
md_ready  out  1  mul/div result accepted this cycle when md_valid & md_ready
md_rd  in  ADDR_W  mul/div lo destination
md_lo  in  DATA_W  lo word
md_hi  in  DATA_W  hi word
stall  out  1  freezes pipeline WB for this cycle; pipeline holds its valid/data
dst_sel  out  2  mux select: 0 rd, 1 rt, 2 HI_REG
wb_en  out  1  register-file write enable
wb_addr  out  ADDR_W  write address
wb_data  out  DATA_W  write data
err  out  1  sticky collision flag (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): state IDLE, starve counter 0, hold registers 0.
  - Outputs at reset: wb_en 0, wb_addr 0, wb_data 0, dst_sel 0, stall 0, md_ready 0, err 0.
  - md_ready goes 1 on the first clock after rst_n deasserts.
- Write outputs (wb_en, wb_addr, wb_data, dst_sel) are registered. A source granted in cycle N appears on the write port in cycle N+1. wb_en pulses one cycle per granted write.
- FSM: IDLE -> MD_LO -> MD_HI -> IDLE.
  - md_ready = (state == IDLE).
  - On the md_valid & md_ready handshake, capture md_rd/md_lo/md_hi into hold registers and go to MD_LO. The handshake itself grants no write.
  - MD_LO: when granted, write md_lo to hold_rd with dst_sel 0, then go to MD_HI.
  - MD_HI: when granted, write md_hi to HI_REG with dst_sel 2, then go to IDLE.
- Pipeline priority:
  - Pipeline write in a cycle = alu_valid | ld_valid. If both are asserted, load wins.
  - ld write: dst_sel 1, addr ld_rt. alu write: dst_sel 0, addr alu_rd.
  - A pending mul/div half is granted only in cycles with no pipeline write, or when stall is asserted.
- Starvation:
  - The counter increments on each cycle where a pipeline write is granted while state is MD_LO or MD_HI.
  - When the counter reaches STARVE_MAX, assert stall for exactly one cycle. In that cycle grant the mul/div half and deny the pipeline write. Then clear the counter.
  - The counter also clears on every mul/div grant and on entry to IDLE.
- WAW squash:
  - If a granted pipeline write targets hold_rd while in MD_LO, the lo write is dropped and the FSM goes to MD_HI.
  - If it targets HI_REG while in MD_HI, the hi write is dropped and the FSM goes to IDLE.
  - The pipeline write always proceeds, because it is younger.
- md_valid while not in IDLE: not accepted; the mul/div unit holds its outputs.
- A new handshake is possible in the cycle the FSM returns to IDLE (the next edge), never the same cycle as the hi grant.
- Reset mid-sequence discards held mul/div results with no partial write.

Optional Feature:
Macro WBARB_COLLIDE_CHK_EN.
- Defined: err is set on any cycle with alu_valid & ld_valid, and stays set until reset. The load still wins.
- Undefined: err is tied 0, no checking logic is built, and the load wins silently.

Decomposition:
- Shared package: dst_sel encodings (SEL_RD = 0, SEL_RT = 1, SEL_HI = 2); FSM state typedef (IDLE, MD_LO, MD_HI); default widths DATA_W and ADDR_W.
- One natural sub-module, wb_starve_cnt: starvation counter with STARVE_MAX compare, producing the one-cycle force pulse.

Test Plan:
- Reset release: after rst_n rises, wb_en = 0 and md_ready = 1. alu_valid with rd = 3 and data 0x1234 -> next cycle wb_en = 1, addr 3, data 0x1234, dst_sel 0.
- Idle pipeline, md handshake with rd = 5, lo 0xAAAA, hi 0x5555 -> md_ready drops. Writes appear on consecutive cycles: (5, 0xAAAA, sel 0), then (0, 0x5555, sel 2). md_ready returns to 1 after.
- md pending plus continuous alu writes -> 4 alu writes, then one stall cycle carrying the lo write. Four more alu writes, then a stall cycle carrying the hi write.
- md pending with rd = 7, then alu write to rd = 7 -> lo write never occurs; hi still written to R0.
- alu_valid and ld_valid together (ld_rt = 2) -> write to 2 with dst_sel 1. err = 1 only when WBARB_COLLIDE_CHK_EN is defined.
- Reset asserted while in MD_HI -> wb_en = 0 immediately, no R0 write; after reset the FSM is IDLE.

Source files
------------

// File: rtl/reg_wb_arbiter_pkg.sv
// reg_wb_arbiter_pkg: shared encodings and default widths for the writeback arbiter
//   SEL_RD/SEL_RT/SEL_HI : register-destination mux select codes
//   state_t              : mul/div writeback sequence (IDLE -> MD_LO -> MD_HI)
//   DEF_DATA_W/DEF_ADDR_W: default register data/address widths
package reg_wb_arbiter_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;
    localparam logic [1:0] SEL_RD = 2'd0;
    localparam logic [1:0] SEL_RT = 2'd1;
    localparam logic [1:0] SEL_HI = 2'd2;
    typedef enum logic [1:0] {IDLE = 2'd0, MD_LO = 2'd1, MD_HI = 2'd2} state_t;
endpackage

// File: rtl/wb_starve_cnt.sv
// wb_starve_cnt: counts pipeline writes that bypass a pending mul/div half
//   clk, rst_n : clock, async active-low reset
//   inc        : a pipeline write was granted while a mul/div half is pending
//   clr        : mul/div half granted or sequence ended
//   fire       : counter at STARVE_MAX; forces the mul/div half this cycle
module wb_starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic fire
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + CW'(1);
    end
    // The forced grant clears the counter, so fire lasts exactly one cycle.
    assign fire = cnt == CW'(STARVE_MAX);
endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: single register-file write port shared by the WB stage and mul/div
//   alu_*/ld_*     : pipeline writeback sources (load wins when both valid)
//   md_*           : mul/div result handshake; lo -> md_rd, hi -> HI_REG
//   stall          : pipeline WB frozen this cycle to let a starved mul/div half through
//   dst_sel/wb_*   : registered write port, one cycle after the grant
//   err            : sticky alu/load collision flag, built only with WBARB_COLLIDE_CHK_EN
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int HI_REG     = 0,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_rt,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [ADDR_W-1:0] md_rd,
    input  logic [DATA_W-1:0] md_lo,
    input  logic [DATA_W-1:0] md_hi,
    output logic              stall,
    output logic [1:0]        dst_sel,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              err
);
    localparam logic [ADDR_W-1:0] HI_A = ADDR_W'(HI_REG);
    state_t            state, state_n;
    logic              alive, pipe, pend, hs, pipe_gnt, md_gnt, squash;
    logic [ADDR_W-1:0] hold_rd, p_addr, m_addr;
    logic [DATA_W-1:0] hold_lo, hold_hi, p_data, m_data;
    logic [1:0]        p_sel, m_sel;
    assign pipe     = alu_valid | ld_valid;
    assign p_addr   = ld_valid ? ld_rt : alu_rd;
    assign p_data   = ld_valid ? ld_data : alu_data;
    assign p_sel    = ld_valid ? SEL_RT : SEL_RD;
    assign pend     = state != IDLE;
    // alive keeps md_ready low until the first clock after reset release
    assign md_ready = alive & ~pend;
    assign hs       = md_valid & md_ready;
    assign pipe_gnt = pipe & ~stall;
    assign md_gnt   = pend & (~pipe | stall);
    assign m_addr   = (state == MD_HI) ? HI_A : hold_rd;
    assign m_data   = (state == MD_HI) ? hold_hi : hold_lo;
    assign m_sel    = (state == MD_HI) ? SEL_HI : SEL_RD;
    // A younger pipeline write to the same register makes the pending half obsolete.
    assign squash   = pipe_gnt & pend & (p_addr == m_addr);
    assign state_n  = hs ? MD_LO
                    : (md_gnt | squash) ? ((state == MD_LO) ? MD_HI : IDLE)
                    : state;
    wb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (pipe_gnt & pend),
        .clr  (md_gnt | (squash & (state == MD_HI))),
        .fire (stall)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            alive   <= 1'b0;
            hold_rd <= '0;
            hold_lo <= '0;
            hold_hi <= '0;
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            dst_sel <= SEL_RD;
        end else begin
            state   <= state_n;
            alive   <= 1'b1;
            if (hs) begin
                hold_rd <= md_rd;
                hold_lo <= md_lo;
                hold_hi <= md_hi;
            end
            wb_en   <= pipe_gnt | md_gnt;
            wb_addr <= pipe_gnt ? p_addr : m_addr;
            wb_data <= pipe_gnt ? p_data : m_data;
            dst_sel <= pipe_gnt ? p_sel : m_sel;
        end
    end
`ifdef WBARB_COLLIDE_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (alu_valid & ld_valid)
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif
endmodule
